// File: rtl/lane_judge.sv
// Multi-lane rhythm-game hit judge: per-lane key capture, head-note grading
// against song time, one judgement per cycle, and score / combo tracking.
module lane_judge #(
  parameter int LANES       = 4,
  parameter int TIME_W      = 16,
  parameter int PERFECT_WIN = 3,
  parameter int GREAT_WIN   = 8,
  parameter int SCORE_W     = 20,
  parameter int COMBO_W     = 10,
  localparam int LW         = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      run,
  input  logic                      tick,
  input  logic [LANES-1:0]          keys,
  input  logic [LANES-1:0]          note_valid,
  input  logic [LANES*TIME_W-1:0]   note_time,
  output logic [LANES-1:0]          note_pop,
  output logic [TIME_W-1:0]         song_time,
  output logic                      judge_valid,
  output logic [LW-1:0]             judge_lane,
  output logic [1:0]                judge_grade,
  output logic [SCORE_W-1:0]        score,
  output logic [COMBO_W-1:0]        combo,
  output logic [COMBO_W-1:0]        max_combo
);

  localparam logic [1:0] GRADE_MISS    = 2'd0;
  localparam logic [1:0] GRADE_GREAT   = 2'd1;
  localparam logic [1:0] GRADE_PERFECT = 2'd2;

  localparam logic signed [TIME_W:0] PERFECT_S = (TIME_W+1)'(PERFECT_WIN);
  localparam logic signed [TIME_W:0] GREAT_S   = (TIME_W+1)'(GREAT_WIN);

  localparam int          SX          = SCORE_W + 9;
  localparam logic [8:0]  PTS_PERFECT = 9'd300;
  localparam logic [8:0]  PTS_GREAT   = 9'd100;

  logic [TIME_W-1:0]  song_time_q, song_time_d;
  logic [LANES-1:0]   sync1_q, sync2_q, prev_q;
  logic [LANES-1:0]   pending_q, pending_d;
  logic [LANES-1:0]   pop_q, pop_d;
  logic               jv_q, jv_d;
  logic [LW-1:0]      lane_q, lane_d;
  logic [1:0]         grade_q, grade_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [COMBO_W-1:0] combo_q, combo_d;
  logic [COMBO_W-1:0] maxc_q, maxc_d;

  logic [LANES-1:0]        rise;
  logic [LANES-1:0]        late;
  logic [LANES-1:0]        cand;
  logic signed [TIME_W:0]  diff [LANES];

  logic                    found;
  logic [LW-1:0]           sel_lane;
  logic [LANES-1:0]        sel_onehot;
  logic                    sel_late;
  logic                    sel_nv;
  logic signed [TIME_W:0]  sel_diff;
  logic                    in_perfect;
  logic                    in_great;

  logic [LANES-1:0]        clr;
  logic                    hit;
  logic [8:0]              pts;
  logic [SX-1:0]           score_sum;

  assign rise = sync2_q & ~prev_q;

  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      diff[i] = $signed({1'b0, song_time_q}) - $signed({1'b0, note_time[i*TIME_W +: TIME_W]});
      late[i] = run && note_valid[i] && (diff[i] > GREAT_S);
    end
  end

  // A lane popped last cycle is masked so its queue can present the next note.
  assign cand = (late | pending_q) & ~pop_q;

  always_comb begin
    found      = 1'b0;
    sel_lane   = '0;
    sel_onehot = '0;
    sel_late   = 1'b0;
    sel_nv     = 1'b0;
    sel_diff   = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (cand[i] && !found) begin
        found         = 1'b1;
        sel_lane      = LW'(i);
        sel_onehot[i] = 1'b1;
        sel_late      = late[i];
        sel_nv        = note_valid[i];
        sel_diff      = diff[i];
      end
    end
  end

  assign in_perfect = (sel_diff >= -PERFECT_S) && (sel_diff <= PERFECT_S);
  assign in_great   = (sel_diff >= -GREAT_S)   && (sel_diff <= GREAT_S);

  always_comb begin
    pop_d   = '0;
    jv_d    = 1'b0;
    lane_d  = lane_q;
    grade_d = grade_q;
    clr     = '0;
    hit     = 1'b0;
    pts     = '0;
    if (found) begin
      if (sel_late) begin
        jv_d    = 1'b1;
        lane_d  = sel_lane;
        grade_d = GRADE_MISS;
        pop_d   = sel_onehot;
      end else begin
        // Press: always consumed; a press with no note in window is a ghost.
        clr = sel_onehot;
        if (sel_nv && in_perfect) begin
          jv_d    = 1'b1;
          lane_d  = sel_lane;
          grade_d = GRADE_PERFECT;
          pop_d   = sel_onehot;
          hit     = 1'b1;
          pts     = PTS_PERFECT;
        end else if (sel_nv && in_great) begin
          jv_d    = 1'b1;
          lane_d  = sel_lane;
          grade_d = GRADE_GREAT;
          pop_d   = sel_onehot;
          hit     = 1'b1;
          pts     = PTS_GREAT;
        end
      end
    end
  end

  always_comb begin
    score_sum = SX'(score_q) + SX'(pts);
    score_d   = score_q;
    combo_d   = combo_q;
    if (hit) begin
      score_d = (|score_sum[SX-1:SCORE_W]) ? '1 : score_sum[SCORE_W-1:0];
      combo_d = (combo_q == '1) ? combo_q : combo_q + COMBO_W'(1);
    end else if (jv_d) begin
      combo_d = '0;
    end
    maxc_d = (combo_d > maxc_q) ? combo_d : maxc_q;
  end

  always_comb begin
    pending_d   = (pending_q & ~clr) | (rise & ~pending_q & {LANES{run}});
    song_time_d = song_time_q;
    if (run && tick && (song_time_q != '1)) begin
      song_time_d = song_time_q + TIME_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      song_time_q <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      prev_q      <= '0;
      pending_q   <= '0;
      pop_q       <= '0;
      jv_q        <= 1'b0;
      lane_q      <= '0;
      grade_q     <= '0;
      score_q     <= '0;
      combo_q     <= '0;
      maxc_q      <= '0;
    end else begin
      song_time_q <= song_time_d;
      sync1_q     <= keys;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      pending_q   <= pending_d;
      pop_q       <= pop_d;
      jv_q        <= jv_d;
      lane_q      <= lane_d;
      grade_q     <= grade_d;
      score_q     <= score_d;
      combo_q     <= combo_d;
      maxc_q      <= maxc_d;
    end
  end

  assign song_time   = song_time_q;
  assign note_pop    = pop_q;
  assign judge_valid = jv_q;
  assign judge_lane  = lane_q;
  assign judge_grade = grade_q;
  assign score       = score_q;
  assign combo       = combo_q;
  assign max_combo   = maxc_q;

endmodule
